pc_fetch: RTL
=============

# pc_fetch

Instruction-fetch front end of the single-issue MIPS datapath. It holds the program counter and drives the PC+4 `add` instance with the current PC and the constant 4. It takes the adder result back as the sequential next PC and addresses instruction memory. The fetched word is captured into the IF/ID pipeline register consumed by decode, and branch/jump redirects, stalls, flushes and misaligned-target faults are handled here.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; must be word-aligned.
- `NOP_INSTR`, default 32'h0000_0000: instruction placed in IF/ID on reset, flush or fault (sll $0,$0,0).
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `stall`, input, 1: hazard unit hold request.
- `redirect`, input, 1: a taken branch or jump, resolved in a later stage.
- `redirect_pc`, input, 32: target address, sampled when `redirect`=1.
- `adder_a`, output, 32: current PC, connected to `add.a`.
- `adder_b`, output, 32: constant 32'd4, connected to `add.b`.
- `pc_plus4`, input, 32: driven by `add.out`.
- `imem_addr`, output, 32: current PC, for the combinational-read instruction memory.
- `imem_rdata`, input, 32: instruction at `imem_addr`, valid in the same cycle.
- `if_id_valid`, output, 1: IF/ID holds a real instruction.
- `if_id_instr`, output, 32: captured instruction.
- `if_id_pc4`, output, 32: PC+4 of the captured instruction.
- `fetch_fault`, output, 1: sticky flag; a misaligned redirect target was seen.

## Operation
- `adder_a` and `imem_addr` are both the `pc` register, driven combinationally. `adder_b` is always 4.
- The state machine has three states: BOOT, RUN and HALT.
- **Reset (async, `rst_n`=0):**
  - `pc`=RESET_PC and state=BOOT.
  - `if_id_valid`=0, `if_id_instr`=NOP_INSTR and `if_id_pc4`=0.
  - `fetch_fault`=0.
- **BOOT:**
  - The first edge after reset deassertion moves the block to RUN.
  - `pc` and IF/ID are unchanged in this cycle, and `if_id_valid` stays 0.
  - `stall` and `redirect` are ignored in BOOT.
- **RUN:** each edge applies exactly one of the following, in this priority order.
  1. `redirect`=1 with `redirect_pc[1:0]`≠0:
     - state goes to HALT and `fetch_fault`=1.
     - `pc` holds its value.
     - IF/ID is flushed (`if_id_valid`=0, `if_id_instr`=NOP_INSTR).
  2. `redirect`=1 with an aligned target:
     - `pc`=`redirect_pc` and IF/ID is flushed.
     - This applies even if `stall`=1, because the redirect overrides the stall.
  3. `stall`=1: `pc` and all of IF/ID hold their values.
  4. Otherwise:
     - `pc`=`pc_plus4`.
     - `if_id_instr`=`imem_rdata` and `if_id_pc4`=`pc_plus4`.
     - `if_id_valid`=1.
- **HALT:**
  - Everything is frozen: `if_id_valid`=0 and `fetch_fault`=1.
  - Only `rst_n` leaves HALT.
- **Arithmetic:** all addition is done in the external adder and is 32-bit modulo 2^32. A PC of 32'hFFFF_FFFC therefore wraps to 0 with no flag raised.
- The block never uses `pc_plus4` except in the sequential case of RUN.

## Timing
- Fetch latency is one cycle: the instruction at PC X appears on `if_id_instr` the edge after X is presented on `imem_addr`.
- After reset release, the first valid IF/ID entry appears on the second rising edge: the BOOT edge, then the first RUN capture.
- A redirect asserted in cycle n gives:
  - `pc`=target after edge n;
  - a bubble (`if_id_valid`=0) after edge n;
  - the target instruction valid after edge n+1.
- A stall holds for as many cycles as it is asserted, and the outputs are bit-identical throughout.
- Asserting `rst_n` low mid-stream clears all state immediately, without waiting for a clock edge.
- All outputs are registered, except `adder_a`/`imem_addr` (which equal the `pc` register) and the constant `adder_b`.

## Test plan
- **Reset values:** hold `rst_n`=0, then release.
  - While in reset: `imem_addr`=0, `if_id_valid`=0, `if_id_instr`=0, `fetch_fault`=0.
  - After the 2nd edge: `if_id_valid`=1 and `if_id_pc4`=4.
- **Sequential fetch:** imem returns 32'h2008_0005 at address 0, 32'h2009_0003 at address 4, and 32'h0109_5020 at address 8.
  - Over three RUN edges, `imem_addr` steps 4, 8, 12.
  - `if_id_instr` follows the imem words in order, and `if_id_pc4` steps 4, 8, 12.
- **Stall:** assert `stall` for 2 cycles at `pc`=8.
  - `imem_addr` stays 8 and IF/ID is unchanged.
  - After release, the next edge captures address 8 and `pc` becomes 12.
- **Redirect with stall:** at `pc`=12, drive `redirect`=1, `redirect_pc`=32'h40 and `stall`=1.
  - `pc`=32'h40 and `if_id_valid`=0.
  - On the next edge, `if_id_pc4`=32'h44 and `if_id_valid`=1.
- **Misaligned redirect:** drive `redirect_pc`=32'h42.
  - `fetch_fault`=1 and `if_id_valid`=0.
  - `pc` is frozen for 10 cycles regardless of inputs.
  - Pulsing `rst_n` clears the fault and sets `pc` back to RESET_PC.
- **Wrap-around and async reset:**
  - Redirect to 32'hFFFF_FFFC; the next sequential edge gives `pc`=0.
  - Pull `rst_n` low between edges: outputs reach their reset values with no clock edge.

Source files
------------

// File: rtl/pc_fetch.sv
// Instruction-fetch front end: owns the PC, feeds the external PC+4 adder,
// addresses combinational instruction memory and fills the IF/ID register.
module pc_fetch #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] adder_a,
   output logic [31:0] adder_b,
   input  logic [31:0] pc_plus4,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic        if_id_valid,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_pc4,
   output logic        fetch_fault
);

   // state   | meaning
   // ST_BOOT | first cycle after reset release; PC and IF/ID untouched
   // ST_RUN  | normal fetch: redirect > stall > sequential
   // ST_HALT | misaligned redirect seen; frozen until rst_n
   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        if_id_valid_q, if_id_valid_d;
   logic [31:0] if_id_instr_q, if_id_instr_d;
   logic [31:0] if_id_pc4_q, if_id_pc4_d;
   logic        fetch_fault_q, fetch_fault_d;
   logic        redirect_bad;

   assign redirect_bad = redirect && (redirect_pc[1:0] != 2'b00);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_BOOT;
         pc_q          <= RESET_PC;
         if_id_valid_q <= 1'b0;
         if_id_instr_q <= NOP_INSTR;
         if_id_pc4_q   <= 32'h0000_0000;
         fetch_fault_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         if_id_valid_q <= if_id_valid_d;
         if_id_instr_q <= if_id_instr_d;
         if_id_pc4_q   <= if_id_pc4_d;
         fetch_fault_q <= fetch_fault_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_BOOT: state_d = ST_RUN;
         ST_RUN:  if (redirect_bad) state_d = ST_HALT;
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_BOOT;
      endcase
   end

   always_comb begin
      pc_d          = pc_q;
      if_id_valid_d = if_id_valid_q;
      if_id_instr_d = if_id_instr_q;
      if_id_pc4_d   = if_id_pc4_q;
      fetch_fault_d = fetch_fault_q;
      case (state_q)
         ST_RUN: begin
            if (redirect_bad) begin
               if_id_valid_d = 1'b0;
               if_id_instr_d = NOP_INSTR;
               fetch_fault_d = 1'b1;
            end else if (redirect) begin
               // redirect wins over stall: the stalled instruction is on the wrong path
               pc_d          = redirect_pc;
               if_id_valid_d = 1'b0;
               if_id_instr_d = NOP_INSTR;
            end else if (!stall) begin
               pc_d          = pc_plus4;
               if_id_valid_d = 1'b1;
               if_id_instr_d = imem_rdata;
               if_id_pc4_d   = pc_plus4;
            end
         end
         ST_HALT: begin
            if_id_valid_d = 1'b0;
            fetch_fault_d = 1'b1;
         end
         default: ;
      endcase
   end

   assign adder_a     = pc_q;
   assign adder_b     = 32'd4;
   assign imem_addr   = pc_q;
   assign if_id_valid = if_id_valid_q;
   assign if_id_instr = if_id_instr_q;
   assign if_id_pc4   = if_id_pc4_q;
   assign fetch_fault = fetch_fault_q;

endmodule
